// File: rtl/bound_flasher_seq.sv
// Thermometer LED bar that walks a table of alternating UP/DOWN phases, with flick kickback, loop mode and done pulse.
// Latency: one count step per prescaler tick, all outputs registered; no backpressure, en=0 freezes everything.
module bound_flasher_seq #(
    parameter int                     LED_W   = 16,
    parameter int                     CNT_W   = 5,
    parameter int                     NSTEP   = 6,
    parameter int                     SW      = 3,
    parameter logic [NSTEP*CNT_W-1:0] BOUNDS  = {5'd0, 5'd7, 5'd0, 5'd11, 5'd5, 5'd16},
    parameter int                     KICK_LO = 0,
    parameter int                     KICK_HI = 5,
    parameter int                     DIV     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flick,
    input  logic             en,
    input  logic             loop,
    output logic [LED_W-1:0] LED,
    output logic [CNT_W-1:0] count,
    output logic [SW-1:0]    step,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

    localparam int               PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]    PMAX = PW'(DIV - 1);
    localparam logic [SW-1:0]    LAST = SW'(NSTEP - 1);
    localparam logic [CNT_W-1:0] KLO  = CNT_W'(KICK_LO);
    localparam logic [CNT_W-1:0] KHI  = CNT_W'(KICK_HI);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [SW-1:0]    step_q, step_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             done_q, done_d;
    logic             busy_q;
    logic             tick;
    logic             finish;
    logic [CNT_W-1:0] bound;

    always_comb begin
        bound = '0;
        for (int k = 0; k < NSTEP; k++) begin
            if (step_q == SW'(k)) bound = BOUNDS[k*CNT_W +: CNT_W];
        end
    end

    assign tick = en && (presc_q == PMAX);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        step_d  = step_q;
        presc_d = presc_q;
        done_d  = 1'b0;
        finish  = 1'b0;
        if (en) presc_d = (presc_q == PMAX) ? '0 : presc_q + 1'b1;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    count_d = '0;
                    if (flick) begin
                        state_d = UP;
                        step_d  = '0;
                    end
                end
                UP: begin
                    if (count_q < bound) begin
                        count_d = count_q + 1'b1;
                    end else if (step_q == LAST) begin
                        finish = 1'b1;
                    end else begin
                        state_d = DOWN;
                        count_d = count_q - 1'b1;
                        step_d  = step_q + 1'b1;
                    end
                end
                DOWN: begin
                    // Kickback outranks the normal move, but never on the final phase.
                    if (flick && (count_q == KLO || count_q == KHI) && step_q != LAST) begin
                        state_d = UP;
                        step_d  = step_q - 1'b1;
                    end else if (count_q > bound) begin
                        count_d = count_q - 1'b1;
                    end else if (step_q != LAST) begin
                        state_d = UP;
                        count_d = count_q + 1'b1;
                        step_d  = step_q + 1'b1;
                    end else begin
                        finish = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (finish) begin
                done_d = 1'b1;
                step_d = '0;
                if (loop) begin
                    state_d = UP;
                end else begin
                    state_d = IDLE;
                    count_d = '0;
                end
            end
        end
    end

    always_comb begin
        led_d = '0;
        for (int i = 0; i < LED_W; i++) led_d[i] = (i < int'(count_d));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            step_q  <= '0;
            led_q   <= '0;
            presc_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            step_q  <= step_d;
            led_q   <= led_d;
            presc_q <= presc_d;
            done_q  <= done_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign LED   = led_q;
    assign count = count_q;
    assign step  = step_q;
    assign busy  = busy_q;
    assign done  = done_q;
endmodule

// File: tb/tb_bound_flasher_seq.sv
// Bench for bound_flasher_seq: default instance plus a DIV=4 instance, expected traces queued per clock
// and compared by an independent negedge monitor.
module tb_bound_flasher_seq;
    logic        clk = 1'b0;
    logic        rst_n, flick, en, loop;
    logic        flick2, en2, loop2;
    logic [15:0] led1, led2;
    logic [4:0]  cnt1, cnt2;
    logic [2:0]  stp1, stp2;
    logic        busy1, busy2, done1, done2;

    bound_flasher_seq u_dut (
        .clk(clk), .rst_n(rst_n), .flick(flick), .en(en), .loop(loop),
        .LED(led1), .count(cnt1), .step(stp1), .busy(busy1), .done(done1)
    );

    bound_flasher_seq #(.DIV(4)) u_div (
        .clk(clk), .rst_n(rst_n), .flick(flick2), .en(en2), .loop(loop2),
        .LED(led2), .count(cnt2), .step(stp2), .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] led;
        logic [4:0]  cnt;
        logic [2:0]  stp;
        logic        bsy;
        logic        dn;
    } obs_t;

    obs_t exp_q[$];
    obs_t exp2_q[$];
    obs_t e1, e2;
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic obs_t mk(input int c, input int s, input logic b, input logic d);
        obs_t        o;
        logic [31:0] t;
        t     = (32'd1 << c) - 32'd1;
        o.led = t[15:0];
        o.cnt = c[4:0];
        o.stp = s[2:0];
        o.bsy = b;
        o.dn  = d;
        return o;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0t: got led=%h count=%0d step=%0d busy=%b done=%b, need led=%h count=%0d step=%0d busy=%b done=%b",
                     name, $time, act.led, act.cnt, act.stp, act.bsy, act.dn,
                     exp.led, exp.cnt, exp.stp, exp.bsy, exp.dn);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e1 = exp_q.pop_front();
            check("dut", {led1, cnt1, stp1, busy1, done1}, e1);
        end
        if (exp2_q.size() > 0) begin
            e2 = exp2_q.pop_front();
            check("div4", {led2, cnt2, stp2, busy2, done2}, e2);
        end
    end

    task automatic ex(input int c, input int s, input logic b, input logic d);
        @(posedge clk);
        #1;
        exp_q.push_back(mk(c, s, b, d));
    endtask

    task automatic ex2(input int c, input int s, input logic b, input logic d, input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            exp2_q.push_back(mk(c, s, b, d));
        end
    endtask

    task automatic ramp(input int a, input int b, input int s);
        if (a <= b) for (int i = a; i <= b; i++) ex(i, s, 1'b1, 1'b0);
        else        for (int i = a; i >= b; i--) ex(i, s, 1'b1, 1'b0);
    endtask

    task automatic tail();
        ramp(1, 16, 0);
        ramp(15, 5, 1);
        ramp(6, 11, 2);
        ramp(10, 0, 3);
        ramp(1, 7, 4);
        ramp(6, 0, 5);
    endtask

    initial begin
        rst_n = 1'b0; flick = 1'b0; en = 1'b1; loop = 1'b0;
        flick2 = 1'b0; en2 = 1'b0; loop2 = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            exp_q.push_back(mk(0, 0, 1'b0, 1'b0));
            exp2_q.push_back(mk(0, 0, 1'b0, 1'b0));
        end
        rst_n = 1'b1;
        repeat (10) ex(0, 0, 1'b0, 1'b0);

        // single flick pulse, full six-phase run, done on the 59th edge after UP entry
        flick = 1'b1;
        ex(0, 0, 1'b1, 1'b0);
        flick = 1'b0;
        tail();
        ex(0, 0, 1'b0, 1'b1);
        ex(0, 0, 1'b0, 1'b0);

        // kickbacks at count 5 of step 1 and count 0 of step 3
        flick = 1'b1;
        ex(0, 0, 1'b1, 1'b0);
        flick = 1'b0;
        ramp(1, 16, 0);
        ramp(15, 5, 1);
        flick = 1'b1;
        ex(5, 0, 1'b1, 1'b0);
        flick = 1'b0;
        ramp(6, 16, 0);
        ramp(15, 5, 1);
        ramp(6, 11, 2);
        ramp(10, 0, 3);
        flick = 1'b1;
        ex(0, 2, 1'b1, 1'b0);
        flick = 1'b0;
        ramp(1, 11, 2);
        ramp(10, 0, 3);
        ramp(1, 7, 4);
        ramp(6, 0, 5);
        ex(0, 0, 1'b0, 1'b1);
        ex(0, 0, 1'b0, 1'b0);

        // flick held through UP phases and the last DOWN phase is ignored
        flick = 1'b1;
        ex(0, 0, 1'b1, 1'b0);
        ramp(1, 16, 0);
        ex(15, 1, 1'b1, 1'b0);
        flick = 1'b0;
        ramp(14, 5, 1);
        ex(6, 2, 1'b1, 1'b0);
        flick = 1'b1;
        ramp(7, 11, 2);
        ex(10, 3, 1'b1, 1'b0);
        flick = 1'b0;
        ramp(9, 0, 3);
        ex(1, 4, 1'b1, 1'b0);
        flick = 1'b1;
        ramp(2, 7, 4);
        ramp(6, 0, 5);
        ex(0, 0, 1'b0, 1'b1);
        flick = 1'b0;
        ex(0, 0, 1'b0, 1'b0);

        // loop mode: restart at step 0 without dropping busy
        loop = 1'b1;
        flick = 1'b1;
        ex(0, 0, 1'b1, 1'b0);
        flick = 1'b0;
        tail();
        ex(0, 0, 1'b1, 1'b1);
        tail();
        loop = 1'b0;
        ex(0, 0, 1'b0, 1'b1);
        ex(0, 0, 1'b0, 1'b0);

        // DIV=4 instance: prescaler frozen at 0 until now
        en2 = 1'b1;
        flick2 = 1'b1;
        ex2(0, 0, 1'b0, 1'b0, 3);
        ex2(0, 0, 1'b1, 1'b0, 1);
        flick2 = 1'b0;
        ex2(0, 0, 1'b1, 1'b0, 3);
        ex2(1, 0, 1'b1, 1'b0, 4);
        ex2(2, 0, 1'b1, 1'b0, 4);
        en2 = 1'b0;
        ex2(2, 0, 1'b1, 1'b0, 7);
        en2 = 1'b1;
        for (int c = 3; c <= 16; c++) ex2(c, 0, 1'b1, 1'b0, 4);
        ex2(15, 1, 1'b1, 1'b0, 4);
        ex2(14, 1, 1'b1, 1'b0, 2);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst", {led2, cnt2, stp2, busy2, done2}, mk(0, 0, 1'b0, 1'b0));
        ex2(0, 0, 1'b0, 1'b0, 2);
        rst_n = 1'b1;
        ex2(0, 0, 1'b0, 1'b0, 3);

        repeat (3) @(posedge clk);
        n_chk++;
        if (exp_q.size() == 0 && exp2_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d/%0d expectations left, need 0/0", exp_q.size(), exp2_q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
